// File: rtl/rv32i_memoryaccess.sv
// rv32i_memoryaccess: load/store stage running one strobe/ack data-bus access per memory instruction.
// Define MEMACCESS_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses without touching the bus.
module rv32i_memoryaccess #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_opcode_load,
  input  logic        i_opcode_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_data_load,
  output logic        o_done,
  output logic        o_stall,
  output logic        o_bus_error,
  output logic        o_stb_data,
  output logic        o_wr_data,
  output logic [31:0] o_data_addr,
  output logic [31:0] o_data_store,
  output logic [3:0]  o_wr_mask,
  input  logic        i_ack_data,
  input  logic [31:0] i_data_in,
  output logic        o_load_misaligned,
  output logic        o_store_misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_n;
  logic [31:0] cnt, ld_fmt, st_fmt;
  logic [2:0] f3;
  logic [1:0] lo;
  logic [7:0] bt;
  logic [15:0] hf;
  logic [3:0] st_mask;
  logic mem, mis, go, timeout;
  assign mem = i_opcode_load | i_opcode_store;
  assign go = (state == IDLE) & i_start & mem & ~mis;
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign o_stb_data = state == REQ;
  assign o_done = state == DONE;
  assign o_stall = (state == REQ) | ((state == IDLE) & i_start & mem);
`ifdef MEMACCESS_MISALIGN_CHECK_EN
  assign mis = ((i_funct3[1:0] == 2'b01) & i_addr[0]) | ((i_funct3 == 3'b010) & (|i_addr[1:0]));
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_load_misaligned <= 1'b0;
      o_store_misaligned <= 1'b0;
    end else begin
      o_load_misaligned <= (state == IDLE) & i_start & mis & i_opcode_load;
      o_store_misaligned <= (state == IDLE) & i_start & mis & i_opcode_store & ~i_opcode_load;
    end
  end
`else
  assign mis = 1'b0;
  assign o_load_misaligned = 1'b0;
  assign o_store_misaligned = 1'b0;
`endif
  assign st_fmt = i_funct3 == 3'b000 ? {4{i_rs2[7:0]}} : i_funct3 == 3'b001 ? {2{i_rs2[15:0]}} : i_rs2;
  assign st_mask = i_funct3 == 3'b000 ? 4'b0001 << i_addr[1:0] :
                   i_funct3 == 3'b001 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign bt = i_data_in[{lo, 3'b000} +: 8];
  assign hf = lo[1] ? i_data_in[31:16] : i_data_in[15:0];
  assign ld_fmt = f3 == 3'b000 ? {{24{bt[7]}}, bt} :
                  f3 == 3'b001 ? {{16{hf[15]}}, hf} :
                  f3 == 3'b100 ? {24'h0, bt} :
                  f3 == 3'b101 ? {16'h0, hf} : i_data_in;
  always_comb begin
    state_n = state;
    if (state == IDLE && i_start) state_n = go ? REQ : DONE;
    else if (state == REQ && (i_ack_data || timeout)) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      f3 <= '0;
      lo <= '0;
      o_data_load <= '0;
      o_bus_error <= 1'b0;
      o_wr_data <= 1'b0;
      o_data_addr <= '0;
      o_data_store <= '0;
      o_wr_mask <= '0;
    end else begin
      o_bus_error <= (state == REQ) & ~i_ack_data & timeout;
      if (go) begin
        cnt <= '0;
        f3 <= i_funct3;
        lo <= i_addr[1:0];
        o_wr_data <= ~i_opcode_load;
        o_data_addr <= {i_addr[31:2], 2'b00};
        o_data_store <= st_fmt;
        o_wr_mask <= i_opcode_load ? 4'b0000 : st_mask;
      end
      if (state == REQ) begin
        cnt <= cnt + 32'd1;
        if (i_ack_data && !o_wr_data) o_data_load <= ld_fmt;
      end
    end
  end
endmodule
